sram_axil_responder: RTL
========================

// Module: sram_axil_responder
// PURPOSE
//  AXI4-Lite slave that answers single-beat write/read transactions from an AXI master
//  and maps them onto one single-port synchronous SRAM with byte enables.
//  Sits between the AXI interconnect/master VIP and the inner SRAM macro in the sram_control IP.
//  Serialises reads and writes, never more than one SRAM access in flight.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32  AXI data width; fixed at 32, byte lanes = 4
//  C_S_AXI_ADDR_WIDTH  32  AXI byte-address width
//  SRAM_ADDR_WIDTH     10  SRAM word-address width (depth = 2**SRAM_ADDR_WIDTH words)
//  SRAM_RD_LATENCY     1   cycles from SRAM read strobe to sram_rdata valid; legal range 1..3
// PORTS
//  ACLK          in   1    clock, all logic on rising edge
//  ARESETN       in   1    asynchronous active-low reset
//  S_AXI_AWADDR  in   ADDR write address (byte)
//  S_AXI_AWPROT  in   3    ignored
//  S_AXI_AWVALID in   1    / S_AXI_AWREADY out 1   AW handshake
//  S_AXI_WDATA   in   32   write data
//  S_AXI_WSTRB   in   4    byte strobes
//  S_AXI_WVALID  in   1    / S_AXI_WREADY  out 1   W handshake
//  S_AXI_BRESP   out  2    00 OKAY, 10 SLVERR
//  S_AXI_BVALID  out  1    / S_AXI_BREADY  in  1   B handshake
//  S_AXI_ARADDR  in   ADDR read address (byte); S_AXI_ARPROT in 3 ignored
//  S_AXI_ARVALID in   1    / S_AXI_ARREADY out 1   AR handshake
//  S_AXI_RDATA   out  32   read data; S_AXI_RRESP out 2 as BRESP
//  S_AXI_RVALID  out  1    / S_AXI_RREADY  in  1   R handshake
//  sram_ce       out  1    SRAM access strobe, one cycle per access
//  sram_we       out  1    1 write, 0 read (valid with sram_ce)
//  sram_be       out  4    byte enables = WSTRB on writes, 4'hF on reads
//  sram_addr     out  SRAM_ADDR_WIDTH  word address = AxADDR[SRAM_ADDR_WIDTH+1:2]
//  sram_wdata    out  32   write data
//  sram_rdata    in   32   read data, valid SRAM_RD_LATENCY cycles after read strobe
// BEHAVIOUR
//  Reset (async assert, sync release): all READY/VALID low, BRESP/RRESP=00, RDATA=0,
//   sram_ce/sram_we=0, sram_be/addr/wdata=0, AW/W latches empty, priority=write, FSM=IDLE.
//  FSM: IDLE -> WR_EXEC -> WR_RESP -> IDLE ; IDLE -> RD_EXEC -> RD_WAIT -> RD_RESP -> IDLE.
//  IDLE: AWREADY=1 while AW latch empty; WREADY=1 while W latch empty; AW and W accepted
//   independently in any order/cycle. ARREADY=1 only when both AW and W latches are empty.
//  Conflict (AR handshake eligible and AW+W both present same cycle): alternate grant,
//   reset favours write; after a served write, read wins next tie, and vice versa.
//  Once AW and W both latched -> WR_EXEC; all READYs low outside IDLE.
//  Address check: bits [ADDR-1:SRAM_ADDR_WIDTH+2] nonzero -> SLVERR, no SRAM strobe.
//   Bits [1:0] ignored (word aligned).
//  WR_EXEC (1 cycle): sram_ce=1, sram_we=1, be=WSTRB; WSTRB=0 -> no strobe, OKAY.
//   Then WR_RESP: BVALID=1 held with stable BRESP until BREADY; clear latches -> IDLE.
//  Write latency: AW+W handshake at edge N -> strobe cycle N+1 -> BVALID from cycle N+2.
//  RD_EXEC (1 cycle): sram_ce=1, sram_we=0, be=4'hF. RD_WAIT counts SRAM_RD_LATENCY
//   cycles, then RDATA <= sram_rdata and RVALID=1 (RD_RESP).
//   SLVERR reads: RDATA=0, no strobe.
//  Read latency: AR handshake edge N -> RVALID from cycle N+2+SRAM_RD_LATENCY.
//  RD_RESP holds RVALID/RDATA/RRESP stable until RREADY, then IDLE.
//  BVALID and RVALID never both high; one outstanding transaction total.
//  Reset mid-operation: transaction dropped, no B/R response, SRAM strobe deasserted.
// TESTING
//  T1 write 1,2,3,4 to 0x0,0x4,0x8,0xC then read back -> RDATA 1,2,3,4, all OKAY.
//  T2 write 0xAABBCCDD to 0x10 then WSTRB=4'b0101 data 0x11223344 -> read 0xAA22CC44.
//  T3 write/read addr 2**(SRAM_ADDR_WIDTH+2) -> BRESP/RRESP=10, RDATA=0, sram_ce never high.
//  T4 W valid 3 cycles before AW -> single write, BVALID 2 cycles after AW handshake.
//  T5 AW+W+AR valid together twice -> order write, read, then read, write (alternation).
//  T6 BREADY/RREADY low 5 cycles -> VALID/RESP/DATA stable, no new READY asserted.
//  T7 ARESETN low during RD_WAIT -> no RVALID, outputs at reset values, next read OK.

Source files
------------

// File: rtl/sram_axil_responder.sv
// sram_axil_responder
// AXI4-Lite slave that serialises single-beat reads and writes onto one
// single-port synchronous SRAM with byte enables. Only one transaction is
// ever outstanding, so BVALID and RVALID are mutually exclusive.
//
// Handshake semantics (all five channels): a transfer happens on the rising
// ACLK edge where VALID and READY are both high. A source never waits for
// READY before raising VALID. Once raised, VALID and its payload stay stable
// until that edge. READY may depend combinationally on VALID. Here every
// READY is low outside IDLE, and low for the first cycle after reset release.
module sram_axil_responder #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 32,
   parameter int SRAM_ADDR_WIDTH    = 10,
   parameter int SRAM_RD_LATENCY    = 1
) (
   input  logic                            ACLK,
   input  logic                            ARESETN,
   // write address channel
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   // write data channel
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   // write response channel
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   // read address channel
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   // read data channel
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   // SRAM port
   output logic                            sram_ce,
   output logic                            sram_we,
   output logic [C_S_AXI_DATA_WIDTH/8-1:0] sram_be,
   output logic [SRAM_ADDR_WIDTH-1:0]      sram_addr,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   sram_wdata,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   sram_rdata,
   // FSM state, for observation only
   output logic [2:0]                      dbg_state
);

   localparam int LANES   = C_S_AXI_DATA_WIDTH / 8;
   localparam int ERR_HI  = C_S_AXI_ADDR_WIDTH - 1;
   localparam int ERR_LO  = SRAM_ADDR_WIDTH + 2;
   localparam int WORD_HI = SRAM_ADDR_WIDTH + 1;
   localparam logic [1:0] LAT_LAST  = 2'(SRAM_RD_LATENCY - 1);
   localparam logic [1:0] RESP_OKAY = 2'b00;
   localparam logic [1:0] RESP_SLV  = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WR_EXEC = 3'd1,
      S_WR_RESP = 3'd2,
      S_RD_EXEC = 3'd3,
      S_RD_WAIT = 3'd4,
      S_RD_RESP = 3'd5
   } state_t;

   state_t state;
   state_t state_nxt;

   // request latches
   logic                          aw_full;
   logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr;
   logic                          w_full;
   logic [C_S_AXI_DATA_WIDTH-1:0] w_data;
   logic [LANES-1:0]              w_strb;
   logic [C_S_AXI_ADDR_WIDTH-1:0] ar_addr;

   // response registers
   logic [1:0]                    bresp_q;
   logic [1:0]                    rresp_q;
   logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;

   // misc control
   logic       run;        // low during reset and the first cycle after release
   logic       prio_read;  // 1: read wins the next AR vs AW+W tie
   logic [1:0] rd_cnt;

   // decoded control
   logic idle;
   logic lat_empty;
   logic tie;
   logic aw_hs;
   logic w_hs;
   logic ar_hs;
   logic wr_go;
   logic wr_err;
   logic rd_err;
   logic wr_strobe;
   logic rd_strobe;
   logic unused_bits;

   assign idle      = run && (state == S_IDLE);
   assign lat_empty = !aw_full && !w_full;

   // A tie is a complete write request and a read request arriving together
   // while nothing is latched; prio_read decides which one is accepted.
   assign tie = idle && lat_empty && S_AXI_AWVALID && S_AXI_WVALID && S_AXI_ARVALID;

   // AR is only taken with both write latches empty, and loses to a full
   // AW+W pair unless it is the read's turn.
   assign S_AXI_ARREADY = idle && lat_empty &&
                          !(S_AXI_AWVALID && S_AXI_WVALID && !prio_read);
   assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;

   // AW and W are accepted independently, but never in the cycle an AR is taken.
   assign S_AXI_AWREADY = idle && !aw_full && !ar_hs;
   assign S_AXI_WREADY  = idle && !w_full && !ar_hs;
   assign aw_hs         = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_hs          = S_AXI_WVALID && S_AXI_WREADY;
   assign wr_go         = (aw_full || aw_hs) && (w_full || w_hs);

   // Any address bit above the SRAM word range makes the access an error.
   assign wr_err = |aw_addr[ERR_HI:ERR_LO];
   assign rd_err = |ar_addr[ERR_HI:ERR_LO];

   // SRAM strobes: one cycle in the EXEC states, suppressed for errors and
   // for writes that carry no enabled byte.
   assign wr_strobe  = (state == S_WR_EXEC) && !wr_err && (|w_strb);
   assign rd_strobe  = (state == S_RD_EXEC) && !rd_err;
   assign sram_ce    = wr_strobe || rd_strobe;
   assign sram_we    = wr_strobe;
   assign sram_be    = wr_strobe ? w_strb : (rd_strobe ? '1 : '0);
   assign sram_addr  = (state == S_RD_EXEC) ? ar_addr[WORD_HI:2] : aw_addr[WORD_HI:2];
   assign sram_wdata = w_data;

   assign S_AXI_BVALID = (state == S_WR_RESP);
   assign S_AXI_BRESP  = bresp_q;
   assign S_AXI_RVALID = (state == S_RD_RESP);
   assign S_AXI_RRESP  = rresp_q;
   assign S_AXI_RDATA  = rdata_q;
   assign dbg_state    = state;

   // Protection bits and the byte offset within a word carry no meaning here.
   assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, aw_addr[1:0], ar_addr[1:0]};

   // FSM state register
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next-state logic; reads win over writes only via the READY gating above
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (ar_hs) begin
               state_nxt = S_RD_EXEC;
            end else if (idle && wr_go) begin
               state_nxt = S_WR_EXEC;
            end
         end
         S_WR_EXEC: state_nxt = S_WR_RESP;
         S_WR_RESP: begin
            if (S_AXI_BREADY) begin
               state_nxt = S_IDLE;
            end
         end
         S_RD_EXEC: state_nxt = S_RD_WAIT;
         S_RD_WAIT: begin
            if (rd_cnt == LAT_LAST) begin
               state_nxt = S_RD_RESP;
            end
         end
         S_RD_RESP: begin
            if (S_AXI_RREADY) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // READY enable: keeps all READYs low until one cycle after reset release
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         run <= 1'b0;
      end else begin
         run <= 1'b1;
      end
   end

   // Write request latches, emptied when the B response is accepted
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         aw_full <= 1'b0;
         aw_addr <= '0;
         w_full  <= 1'b0;
         w_data  <= '0;
         w_strb  <= '0;
      end else begin
         if (aw_hs) begin
            aw_full <= 1'b1;
            aw_addr <= S_AXI_AWADDR;
         end else if ((state == S_WR_RESP) && S_AXI_BREADY) begin
            aw_full <= 1'b0;
         end
         if (w_hs) begin
            w_full <= 1'b1;
            w_data <= S_AXI_WDATA;
            w_strb <= S_AXI_WSTRB;
         end else if ((state == S_WR_RESP) && S_AXI_BREADY) begin
            w_full <= 1'b0;
         end
      end
   end

   // Read address latch
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         ar_addr <= '0;
      end else if (ar_hs) begin
         ar_addr <= S_AXI_ARADDR;
      end
   end

   // Tie-break priority: flips every time a tie is resolved
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         prio_read <= 1'b0;
      end else if (tie) begin
         prio_read <= !prio_read;
      end
   end

   // Write response code, fixed during the strobe cycle and held through WR_RESP
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         bresp_q <= RESP_OKAY;
      end else if (state == S_WR_EXEC) begin
         bresp_q <= wr_err ? RESP_SLV : RESP_OKAY;
      end
   end

   // Read latency counter and read data capture at the end of RD_WAIT
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         rd_cnt  <= 2'd0;
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
      end else begin
         if (state == S_RD_EXEC) begin
            rd_cnt <= 2'd0;
         end else if (state == S_RD_WAIT) begin
            rd_cnt <= rd_cnt + 2'd1;
         end
         if ((state == S_RD_WAIT) && (rd_cnt == LAT_LAST)) begin
            rdata_q <= rd_err ? '0 : sram_rdata;
            rresp_q <= rd_err ? RESP_SLV : RESP_OKAY;
         end
      end
   end

endmodule
